lpc_record_serializer: RTL and testbench
========================================

// Module: lpc_record_serializer
// PURPOSE
//  Downstream of the lpc sniffer core. Captures each decoded LPC cycle record
//  (out_cyctype_dir/addr/data/data_size, qualified by out_clock_enable) into a
//  small FIFO, then emits it as a byte-framed stream over a valid/ready port to
//  the host-link transmitter (UART/USB bridge). Absorbs bursts of back-to-back
//  LPC cycles; counts records dropped on overflow.
// PARAMETERS
//  FIFO_DEPTH  8     record slots, power of two, >=2
//  SYNC_BYTE   8'hA5 first byte of every frame
// PORTS
//  lpc_clock      in   1   single clock, all logic on rising edge
//  lpc_reset      in   1   synchronous, active-high reset
//  in_valid       in   1   one-cycle strobe: record fields valid (sniffer out_clock_enable)
//  in_cyctype_dir in   4   cycle type / direction nibble
//  in_addr        in   32  cycle address
//  in_data        in   32  cycle data, right-aligned
//  in_data_size   in   4   data byte count
//  out_byte       out  8   stream byte
//  out_valid      out  1   out_byte valid
//  out_ready      in   1   consumer accepts out_byte this cycle
//  drop_count     out  8   records dropped on FIFO full, saturates at 8'hFF
//  busy           out  1   FIFO non-empty or frame in progress
// BEHAVIOUR
//  Reset: out_byte=0, out_valid=0, drop_count=0, busy=0, FIFO empty, state IDLE.
//   Reset mid-frame abandons the frame and discards FIFO contents.
//  Push: on in_valid, 72-bit record {ct_dir,size,addr,data} written if FIFO not
//   full, or if full and a pop happens the same cycle. Otherwise dropped and
//   drop_count increments (saturating). Record is poppable the next cycle.
//  Frame: SYNC_BYTE, {ct_dir,size}, addr[31:24],[23:16],[15:8],[7:0], then N data
//   bytes, N = min(size,4), most-significant of the N first (N=1 -> data[7:0];
//   N=2 -> data[15:8],data[7:0]). size 0 -> no data bytes; size>4 -> header keeps
//   raw size, N=4. Frame length 6+N bytes.
//  Handshake: byte transfers when out_valid&&out_ready. out_byte held stable and
//   out_valid held high until transfer; out_valid never drops mid-frame while
//   stalled. Next byte presented the cycle after transfer (1 byte/clk max).
//  FSM: IDLE -> (FIFO non-empty) pop into frame register, LOAD -> SYNC -> HDR ->
//   ADDR(idx 3..0) -> DATA(idx N-1..0, skipped if N=0) -> IDLE. Each state except
//   IDLE/LOAD advances only on transfer. IDLE re-checks FIFO the cycle after the
//   last byte transfers.
//  Latency: in_valid at cycle T with FIFO empty and FSM IDLE -> out_valid high with
//   SYNC_BYTE at T+3 (T+1 visible, T+2 pop/load, T+3 present).
//  Pop occurs only in IDLE; FIFO pointers wrap modulo FIFO_DEPTH; full/empty from
//   an extra pointer bit. busy = !empty || state!=IDLE.
// STRUCTURE
//  lpc_defs.vh (shared include): record field offsets/width (72), SYNC_BYTE
//   default, FSM state encodings, cyctype/dir constants shared with sniffer core.
//  Sub-module lpc_fifo: synchronous FIFO, WIDTH/DEPTH params, push/pop/full/empty,
//   push-when-full-with-pop allowed. Serializer FSM + frame register in top.
// TESTING
//  1 mem read, ct_dir=4, addr=32'hAFFE7FE5, data=8'h6C, size=1, out_ready=1 ->
//    bytes A5,41,AF,FE,7F,E5,6C; SYNC appears 3 clk after in_valid; busy falls after.
//  2 io write ct_dir=2, addr=32'h0000002E, data=16'h1234, size=2, out_ready toggling
//    1/0 -> A5,22,00,00,00,2E,12,34; out_byte stable across every stall.
//  3 FIFO_DEPTH+3 back-to-back in_valid with out_ready=0 -> first DEPTH accepted
//    (plus none while popped record sits in frame reg... exactly DEPTH+1 frames
//    out), drop_count=2; release ready -> frames in arrival order, no gaps.
//  4 size=0 and size=7 records -> 6-byte frame (header x0) and 10-byte frame
//    (header x7, 4 data bytes).
//  5 300 drops with out_ready=0 -> drop_count saturates at FF.
//  6 lpc_reset asserted mid-frame after 3 bytes -> next cycle out_valid=0,
//    drop_count=0, busy=0; new record afterwards framed correctly from SYNC.

Source files
------------

// File: rtl/lpc_record_serializer_pkg.sv
// Shared definitions for the LPC record serializer: record layout, framing
// constants, FSM state encoding and cycle-type constants shared with the sniffer.
package lpc_record_serializer_pkg;

  // Record layout: {ct_dir[3:0], size[3:0], addr[31:0], data[31:0]}
  localparam int unsigned RecWidth    = 72;
  localparam int unsigned RecDataLsb  = 0;
  localparam int unsigned RecAddrLsb  = 32;
  localparam int unsigned RecSizeLsb  = 64;
  localparam int unsigned RecCtDirLsb = 68;

  localparam logic [7:0] SyncByteDefault = 8'hA5;

  // Cycle type / direction nibble values produced by the sniffer core
  localparam logic [3:0] CtDirIoRead   = 4'h0;
  localparam logic [3:0] CtDirIoWrite  = 4'h2;
  localparam logic [3:0] CtDirMemRead  = 4'h4;
  localparam logic [3:0] CtDirMemWrite = 4'h6;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSync,
    StHdr,
    StAddr,
    StData
  } ser_state_e;

  // Number of data bytes emitted for a given size field; sizes above 4 clamp to 4
  function automatic logic [2:0] data_byte_count(input logic [3:0] size);
    return (size > 4'd4) ? 3'd4 : size[2:0];
  endfunction

endpackage

// File: rtl/lpc_record_serializer_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty. A push while full is
// accepted when a pop happens in the same cycle. Read data is the current head.
module lpc_record_serializer_fifo #(
  parameter int unsigned WIDTH = 72,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer advance
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PtrOne;
    if (do_pop)  rptr_d = rptr_q + PtrOne;
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/lpc_record_serializer.sv
// Buffers decoded LPC cycle records in a FIFO and emits each one as a byte frame
// (sync, header, 4 address bytes, 0..4 data bytes) over a valid/ready port.
module lpc_record_serializer
  import lpc_record_serializer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  SYNC_BYTE  = SyncByteDefault
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic        in_valid,
  input  logic [3:0]  in_cyctype_dir,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_data_size,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  drop_count,
  output logic        busy
);

  ser_state_e          state_q, state_d;
  logic [RecWidth-1:0] frame_q, frame_d;
  logic [1:0]          idx_q, idx_d;
  logic [7:0]          drop_q, drop_d;

  logic [RecWidth-1:0] rec_wdata, rec_rdata;
  logic                fifo_full, fifo_empty, pop;
  logic                fire;

  logic [3:0]  fr_ct_dir, fr_size;
  logic [31:0] fr_addr, fr_data;
  logic [2:0]  n_bytes, last_idx;

  assign rec_wdata = {in_cyctype_dir, in_data_size, in_addr, in_data};

  lpc_record_serializer_fifo #(
    .WIDTH (RecWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (lpc_clock),
    .rst_i   (lpc_reset),
    .push_i  (in_valid),
    .wdata_i (rec_wdata),
    .pop_i   (pop),
    .rdata_o (rec_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign fr_ct_dir = frame_q[RecCtDirLsb +: 4];
  assign fr_size   = frame_q[RecSizeLsb +: 4];
  assign fr_addr   = frame_q[RecAddrLsb +: 32];
  assign fr_data   = frame_q[RecDataLsb +: 32];
  assign n_bytes   = data_byte_count(fr_size);
  assign last_idx  = n_bytes - 3'd1;

  assign fire       = out_valid && out_ready;
  assign busy       = !fifo_empty || (state_q != StIdle);
  assign drop_count = drop_q;

  // Framing FSM: next state, frame register load and stream outputs
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    pop       = 1'b0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          frame_d = rec_rdata;
          state_d = StLoad;
        end
      end
      StLoad: state_d = StSync;
      StSync: begin
        out_valid = 1'b1;
        out_byte  = SYNC_BYTE;
        if (fire) state_d = StHdr;
      end
      StHdr: begin
        out_valid = 1'b1;
        out_byte  = {fr_ct_dir, fr_size};
        if (fire) begin
          state_d = StAddr;
          idx_d   = 2'd3;
        end
      end
      StAddr: begin
        out_valid = 1'b1;
        out_byte  = fr_addr[{idx_q, 3'b000} +: 8];
        if (fire) begin
          if (idx_q != 2'd0) begin
            idx_d = idx_q - 2'd1;
          end else if (n_bytes == 3'd0) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            idx_d   = last_idx[1:0];
          end
        end
      end
      StData: begin
        out_valid = 1'b1;
        out_byte  = fr_data[{idx_q, 3'b000} +: 8];
        if (fire) begin
          if (idx_q == 2'd0) state_d = StIdle;
          else               idx_d   = idx_q - 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Drop counter: a push is lost only when full and no pop frees a slot
  always_comb begin
    drop_d = drop_q;
    if (in_valid && fifo_full && !pop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // State, frame and counter registers
  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state_q <= StIdle;
      frame_q <= '0;
      idx_q   <= 2'd0;
      drop_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_lpc_record_serializer.sv
// Directed bench for lpc_record_serializer with hand-computed frames.
module tb_lpc_record_serializer;

  localparam int unsigned Depth = 8;

  logic        lpc_clock = 1'b0;
  logic        lpc_reset;
  logic        in_valid;
  logic [3:0]  in_cyctype_dir;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [3:0]  in_data_size;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  drop_count;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] got [128];
  int ngot;

  lpc_record_serializer #(
    .FIFO_DEPTH (Depth),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .lpc_clock      (lpc_clock),
    .lpc_reset      (lpc_reset),
    .in_valid       (in_valid),
    .in_cyctype_dir (in_cyctype_dir),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_data_size   (in_data_size),
    .out_byte       (out_byte),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .drop_count     (drop_count),
    .busy           (busy)
  );

  always #5 lpc_clock = ~lpc_clock;

  task automatic tick;
    @(posedge lpc_clock);
    #1;
  endtask

  task automatic drive_rec(input logic [3:0] ct, input logic [3:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
    in_valid       = 1'b1;
    in_cyctype_dir = ct;
    in_data_size   = sz;
    in_addr        = a;
    in_data        = d;
  endtask

  task automatic do_reset;
    lpc_reset = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    lpc_reset = 1'b0;
  endtask

  // Collect len bytes from the stream under the current out_ready, bounded
  task automatic recv(input int len, input int budget);
    int cyc;
    ngot = 0;
    cyc  = 0;
    while (ngot < len && cyc < budget) begin
      if (out_valid && out_ready) begin
        got[ngot] = out_byte;
        ngot++;
      end
      tick();
      cyc++;
    end
    if (ngot < len) begin
      vectors++;
      miscompares++;
      $display("FAIL recv_timeout: got %0d bytes, expected %0d", ngot, len);
    end
  endtask

  task automatic test_reset;
    do_reset();
    vectors += 4;
    if (out_byte !== 8'h00) begin
      miscompares++; $display("FAIL reset_out_byte: got %h expected 00", out_byte);
    end
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    if (drop_count !== 8'h00) begin
      miscompares++; $display("FAIL reset_drop_count: got %h expected 00", drop_count);
    end
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_mem_read;
    logic [7:0] exp [7] = '{8'hA5, 8'h41, 8'hAF, 8'hFE, 8'h7F, 8'hE5, 8'h6C};
    out_ready = 1'b1;
    drive_rec(4'h4, 4'd1, 32'hAFFE7FE5, 32'h0000006C);
    tick();
    in_valid = 1'b0;
    vectors += 2;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL lat_t1_valid: got %b expected 0", out_valid);
    end
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL lat_t1_busy: got %b expected 1", busy);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL lat_t2_valid: got %b expected 0", out_valid);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_byte !== 8'hA5) begin
      miscompares++;
      $display("FAIL lat_t3_sync: got v=%b b=%h expected v=1 b=a5", out_valid, out_byte);
    end
    recv(7, 50);
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++; $display("FAIL memrd_byte%0d: got %h expected %h", i, got[i], exp[i]);
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL memrd_busy_after: got %b expected 0", busy);
    end
  endtask

  task automatic test_io_write_stall;
    logic [7:0] exp [8] = '{8'hA5, 8'h22, 8'h00, 8'h00, 8'h00, 8'h2E, 8'h12, 8'h34};
    logic [7:0] prev;
    logic       stalled;
    int         n;
    int         cyc;
    out_ready = 1'b0;
    drive_rec(4'h2, 4'd2, 32'h0000002E, 32'h00001234);
    tick();
    in_valid = 1'b0;
    n        = 0;
    cyc      = 0;
    stalled  = 1'b0;
    prev     = 8'h00;
    while (n < 8 && cyc < 100) begin
      out_ready = (cyc % 2 == 1);
      if (stalled) begin
        vectors++;
        if (out_valid !== 1'b1 || out_byte !== prev) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%b b=%h expected v=1 b=%h", out_valid, out_byte, prev);
        end
      end
      if (out_valid && out_ready) begin
        got[n]  = out_byte;
        n++;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        prev    = out_byte;
      end
      tick();
      cyc++;
    end
    vectors++;
    if (n != 8) begin
      miscompares++; $display("FAIL iowr_count: got %0d expected 8", n);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++; $display("FAIL iowr_byte%0d: got %h expected %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    out_ready = 1'b0;
    for (int i = 0; i < Depth + 3; i++) begin
      drive_rec(4'h4, 4'd1, 32'h1000_0000 + 32'(i), 32'(i));
      tick();
    end
    in_valid = 1'b0;
    vectors += 2;
    if (drop_count !== 8'd2) begin
      miscompares++; $display("FAIL b2b_drops: got %0d expected 2", drop_count);
    end
    if (out_valid !== 1'b1 || out_byte !== 8'hA5) begin
      miscompares++;
      $display("FAIL b2b_stalled_sync: got v=%b b=%h expected v=1 b=a5", out_valid, out_byte);
    end
    out_ready = 1'b1;
    recv((Depth + 1) * 7, 400);
    for (int f = 0; f < Depth + 1; f++) begin
      for (int b = 0; b < 7; b++) begin
        case (b)
          0:       e = 8'hA5;
          1:       e = 8'h41;
          2:       e = 8'h10;
          3, 4:    e = 8'h00;
          default: e = 8'(f);
        endcase
        vectors++;
        if (got[f * 7 + b] !== e) begin
          miscompares++;
          $display("FAIL b2b_f%0d_b%0d: got %h expected %h", f, b, got[f * 7 + b], e);
        end
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL b2b_busy_after: got %b expected 0", busy);
    end
  endtask

  task automatic test_size_edge;
    logic [7:0] exp [16] = '{8'hA5, 8'h40, 8'h12, 8'h34, 8'h56, 8'h78,
                             8'hA5, 8'h47, 8'h12, 8'h34, 8'h56, 8'h78,
                             8'hDE, 8'hAD, 8'hBE, 8'hEF};
    out_ready = 1'b1;
    drive_rec(4'h4, 4'd0, 32'h12345678, 32'hDEADBEEF);
    tick();
    drive_rec(4'h4, 4'd7, 32'h12345678, 32'hDEADBEEF);
    tick();
    in_valid = 1'b0;
    recv(16, 100);
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++; $display("FAIL size_byte%0d: got %h expected %h", i, got[i], exp[i]);
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL size_busy_after: got %b expected 0", busy);
    end
  endtask

  task automatic test_drop_saturate;
    do_reset();
    for (int i = 0; i < 309; i++) begin
      drive_rec(4'h6, 4'd4, 32'(i), 32'(i));
      tick();
      if (i == 262) begin
        vectors++;
        if (drop_count !== 8'hFE) begin
          miscompares++; $display("FAIL drop_fe: got %h expected fe", drop_count);
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (drop_count !== 8'hFF) begin
      miscompares++; $display("FAIL drop_sat: got %h expected ff", drop_count);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] exp [8] = '{8'hA5, 8'h22, 8'h00, 8'h00, 8'h00, 8'h2E, 8'h12, 8'h34};
    do_reset();
    drive_rec(4'h4, 4'd1, 32'hAFFE7FE5, 32'h0000006C);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive_rec(4'h2, 4'd2, 32'(i), 32'(i));
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (drop_count !== 8'd2) begin
      miscompares++; $display("FAIL rst_pre_drops: got %0d expected 2", drop_count);
    end
    out_ready = 1'b1;
    recv(3, 20);
    vectors++;
    if (got[0] !== 8'hA5 || got[1] !== 8'h41 || got[2] !== 8'hAF) begin
      miscompares++;
      $display("FAIL rst_pre_bytes: got %h %h %h expected a5 41 af", got[0], got[1], got[2]);
    end
    lpc_reset = 1'b1;
    out_ready = 1'b0;
    tick();
    lpc_reset = 1'b0;
    vectors += 3;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid);
    end
    if (drop_count !== 8'h00) begin
      miscompares++; $display("FAIL rst_mid_drops: got %h expected 00", drop_count);
    end
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_busy: got %b expected 0", busy);
    end
    out_ready = 1'b1;
    drive_rec(4'h2, 4'd2, 32'h0000002E, 32'h00001234);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_byte !== 8'hA5) begin
      miscompares++;
      $display("FAIL rst_new_sync: got v=%b b=%h expected v=1 b=a5", out_valid, out_byte);
    end
    recv(8, 50);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++; $display("FAIL rst_new_byte%0d: got %h expected %h", i, got[i], exp[i]);
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL rst_new_busy: got %b expected 0", busy);
    end
  endtask

  initial begin
    lpc_reset      = 1'b1;
    in_valid       = 1'b0;
    in_cyctype_dir = 4'h0;
    in_addr        = 32'h0;
    in_data        = 32'h0;
    in_data_size   = 4'h0;
    out_ready      = 1'b0;
    test_reset();
    test_mem_read();
    test_io_write_stall();
    test_back_to_back();
    test_size_edge();
    test_drop_saturate();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
